// File: rtl/instr_issue_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : instr_issue_encoder
// Purpose  : Packs field-level requests into 8-bit instructions, queues them
//            and issues them to the decoder with a programmable idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module instr_issue_encoder #(
  parameter int DEPTH = 4,
  parameter int GAP_W = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_opcode,
  input  logic                     in_reg_sel,
  input  logic [3:0]               in_operand,
  input  logic [GAP_W-1:0]         gap,
  input  logic                     flush,
  output logic [7:0]               instr_out,
  output logic                     instr_ena,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic [7:0]               issued_count,
  output logic [3:0]               reject_count
);

  localparam int                 c_ADDR_W     = $clog2(DEPTH);
  localparam logic [c_ADDR_W:0]  c_FULL_LEVEL = DEPTH[c_ADDR_W:0];
  localparam logic [2:0]         c_OP_UNDEF   = 3'b110;
  localparam logic [2:0]         c_OP_NOP     = 3'b111;
  localparam logic [7:0]         c_NOP_WORD   = 8'hE0;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_GAP  = 1'b1;

  logic [7:0]          r_mem [DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_ADDR_W:0]   r_level;
  logic [0:0]          r_state;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [7:0]          r_instr_out;
  logic                r_instr_ena;
  logic [7:0]          r_issued_count;
  logic [3:0]          r_reject_count;

  logic                w_accept;
  logic                w_undef;
  logic                w_enq;
  logic                w_pop;
  logic [7:0]          w_encoded;

  // No full-lookahead: a pop in the same cycle does not reopen the input.
  assign in_ready  = (r_level != c_FULL_LEVEL) && !flush;
  assign w_accept  = in_valid && in_ready;
  assign w_undef   = (in_opcode == c_OP_UNDEF);
  assign w_enq     = w_accept && !w_undef;
  assign w_encoded = (in_opcode == c_OP_NOP) ? c_NOP_WORD
                                             : {in_opcode, in_reg_sel, in_operand};

  // Popping off the registered level means a word written at this edge is
  // never visible to the issue logic until the following edge.
  assign w_pop = (r_state == c_ST_IDLE) && (r_level != '0) && !flush;

  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= w_encoded;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_enq, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= c_ST_IDLE;
      r_gap_cnt   <= '0;
      r_instr_out <= '0;
      r_instr_ena <= 1'b0;
    end else if (flush) begin
      r_state     <= c_ST_IDLE;
      r_gap_cnt   <= '0;
      r_instr_out <= '0;
      r_instr_ena <= 1'b0;
    end else begin
      r_instr_ena <= w_pop;
      case (r_state)
        c_ST_IDLE: begin
          if (w_pop) begin
            r_instr_out <= r_mem[r_rd_ptr];
            if (gap != '0) begin
              r_state   <= c_ST_GAP;
              r_gap_cnt <= gap;
            end
          end
        end
        c_ST_GAP: begin
          r_gap_cnt <= r_gap_cnt - 1'b1;
          if (r_gap_cnt == GAP_W'(1)) begin
            r_state <= c_ST_IDLE;
          end
        end
        default: begin
          r_state   <= c_ST_IDLE;
          r_gap_cnt <= '0;
        end
      endcase
    end
  end

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_issued_count <= '0;
      r_reject_count <= '0;
    end else begin
      if (w_pop) begin
        r_issued_count <= r_issued_count + 8'd1;
      end
      if (w_accept && w_undef && (r_reject_count != 4'hF)) begin
        r_reject_count <= r_reject_count + 4'd1;
      end
    end
  end

  assign instr_out    = r_instr_out;
  assign instr_ena    = r_instr_ena;
  assign level        = r_level;
  assign busy         = (r_level != '0) || (r_state == c_ST_GAP);
  assign issued_count = r_issued_count;
  assign reject_count = r_reject_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_issue_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instr_issue_encoder
// Purpose  : Directed self-checking bench for instr_issue_encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_issue_encoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_opcode = '0;
  logic       in_reg_sel = 1'b0;
  logic [3:0] in_operand = '0;
  logic [3:0] gap = '0;
  logic       flush = 1'b0;
  logic [7:0] instr_out;
  logic       instr_ena;
  logic [2:0] level;
  logic       busy;
  logic [7:0] issued_count;
  logic [3:0] reject_count;

  int total = 0;
  int pass_cnt = 0;
  int cyc = 0;
  logic [7:0] iss_q[$];
  int         iss_t[$];

  instr_issue_encoder #(.DEPTH(4), .GAP_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_reg_sel   (in_reg_sel),
    .in_operand   (in_operand),
    .gap          (gap),
    .flush        (flush),
    .instr_out    (instr_out),
    .instr_ena    (instr_ena),
    .level        (level),
    .busy         (busy),
    .issued_count (issued_count),
    .reject_count (reject_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Issue log: byte and edge index of every strobe, sampled mid-cycle.
  always @(negedge clock) begin
    if (instr_ena === 1'b1) begin
      iss_q.push_back(instr_out);
      iss_t.push_back(cyc);
    end
  end

  task automatic send(input logic [2:0] op, input logic rs, input logic [3:0] opd);
    in_valid = 1'b1; in_opcode = op; in_reg_sel = rs; in_operand = opd;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic test_reset;
    idle(2);
    total++; if ({instr_out, instr_ena, level, busy} !== 13'd0)
      $display("FAIL reset_outputs got out=%h ena=%b level=%0d busy=%b want all 0", instr_out, instr_ena, level, busy);
    else pass_cnt++;
    total++; if ({issued_count, reject_count} !== 12'd0)
      $display("FAIL reset_counters got issued=%0d reject=%0d want 0/0", issued_count, reject_count);
    else pass_cnt++;
    reset = 1'b0; #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready); else pass_cnt++;
    @(posedge clock); #1;
  endtask

  task automatic test_basic;
    int a;
    gap = 4'd0; iss_q.delete(); iss_t.delete();
    send(3'b001, 1'b1, 4'b0011);
    a = cyc;
    total++; if (level !== 3'd1) $display("FAIL basic_level got %0d want 1", level); else pass_cnt++;
    idle(4);
    total++; if (iss_q.size() !== 1) $display("FAIL basic_pulses got %0d want 1", iss_q.size()); else pass_cnt++;
    if (iss_q.size() > 0) begin
      total++; if (iss_q[0] !== 8'h33) $display("FAIL basic_byte got %h want 33", iss_q[0]); else pass_cnt++;
      total++; if (iss_t[0] !== a + 1) $display("FAIL basic_latency got edge %0d want %0d", iss_t[0], a + 1); else pass_cnt++;
    end
    total++; if (issued_count !== 8'd1) $display("FAIL basic_issued got %0d want 1", issued_count); else pass_cnt++;
    total++; if (instr_out !== 8'h33) $display("FAIL basic_hold got %h want 33", instr_out); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL basic_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_nop_undef;
    iss_q.delete(); iss_t.delete();
    send(3'b111, 1'b1, 4'b1111);
    idle(4);
    total++; if (iss_q.size() !== 1) $display("FAIL nop_pulses got %0d want 1", iss_q.size()); else pass_cnt++;
    if (iss_q.size() > 0) begin
      total++; if (iss_q[0] !== 8'hE0) $display("FAIL nop_byte got %h want e0", iss_q[0]); else pass_cnt++;
    end
    in_valid = 1'b1; in_opcode = 3'b110; in_reg_sel = 1'b1; in_operand = 4'h5; #1;
    total++; if (in_ready !== 1'b1) $display("FAIL undef_ready got %b want 1", in_ready); else pass_cnt++;
    @(posedge clock); #1; in_valid = 1'b0;
    idle(3);
    total++; if (iss_q.size() !== 1) $display("FAIL undef_no_issue got %0d pulses want 1", iss_q.size()); else pass_cnt++;
    total++; if (reject_count !== 4'd1) $display("FAIL undef_reject got %0d want 1", reject_count); else pass_cnt++;
    total++; if (level !== 3'd0) $display("FAIL undef_level got %0d want 0", level); else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("FAIL undef_ready_after got %b want 1", in_ready); else pass_cnt++;
    for (int i = 0; i < 13; i++) send(3'b110, 1'b0, 4'(i));
    total++; if (reject_count !== 4'd14) $display("FAIL reject_14 got %0d want 14", reject_count); else pass_cnt++;
    for (int i = 0; i < 3; i++) send(3'b110, 1'b0, 4'(i));
    total++; if (reject_count !== 4'd15) $display("FAIL reject_sat got %0d want 15", reject_count); else pass_cnt++;
    total++; if (issued_count !== 8'd2) $display("FAIL undef_issued got %0d want 2", issued_count); else pass_cnt++;
  endtask

  task automatic test_gap_full;
    logic [7:0] exp_b [5];
    int         exp_d [5];
    exp_b[0] = 8'h80; exp_b[1] = 8'h01; exp_b[2] = 8'h55; exp_b[3] = 8'h6A; exp_b[4] = 8'hBC;
    exp_d[0] = 0;     exp_d[1] = 16;    exp_d[2] = 4;     exp_d[3] = 4;     exp_d[4] = 4;
    iss_q.delete(); iss_t.delete();
    // Long gap after a dummy issue holds the FSM in GAP so the queue fills.
    gap = 4'd15;
    send(3'b100, 1'b0, 4'h0);
    in_valid = 1'b1; in_opcode = 3'b000; in_reg_sel = 1'b0; in_operand = 4'h1;
    @(posedge clock); #1; gap = 4'd3;
    in_opcode = 3'b010; in_reg_sel = 1'b1; in_operand = 4'h5;
    @(posedge clock); #1;
    in_opcode = 3'b011; in_reg_sel = 1'b0; in_operand = 4'hA;
    @(posedge clock); #1;
    in_opcode = 3'b101; in_reg_sel = 1'b1; in_operand = 4'hC;
    @(posedge clock); #1; in_valid = 1'b0;
    total++; if (level !== 3'd4) $display("FAIL full_level got %0d want 4", level); else pass_cnt++;
    total++; if (in_ready !== 1'b0) $display("FAIL full_ready got %b want 0", in_ready); else pass_cnt++;
    idle(12);
    total++; if ({in_ready, level} !== 4'b0_100) $display("FAIL full_hold got ready=%b level=%0d want 0/4", in_ready, level); else pass_cnt++;
    idle(1);
    total++; if ({in_ready, level} !== 4'b1_011) $display("FAIL full_pop got ready=%b level=%0d want 1/3", in_ready, level); else pass_cnt++;
    idle(14);
    total++; if (iss_q.size() !== 5) $display("FAIL gap_pulses got %0d want 5", iss_q.size()); else pass_cnt++;
    for (int i = 0; i < 5 && i < iss_q.size(); i++) begin
      total++; if (iss_q[i] !== exp_b[i]) $display("FAIL gap_byte[%0d] got %h want %h", i, iss_q[i], exp_b[i]); else pass_cnt++;
      if (i > 0) begin
        total++; if (iss_t[i] - iss_t[i-1] !== exp_d[i])
          $display("FAIL gap_spacing[%0d] got %0d want %0d", i, iss_t[i] - iss_t[i-1], exp_d[i]);
        else pass_cnt++;
      end
    end
    total++; if (issued_count !== 8'd7) $display("FAIL gap_issued got %0d want 7", issued_count); else pass_cnt++;
  endtask

  task automatic stream(input int n, input int base);
    logic [7:0] exp_q[$];
    logic [2:0] op;
    logic       rs;
    logic [3:0] opd;
    gap = 4'd0; iss_q.delete(); iss_t.delete();
    for (int i = 0; i < n; i++) begin
      op = 3'((base + i) % 6); rs = 1'((base + i) >> 1); opd = 4'((base + i) >> 2);
      exp_q.push_back({op, rs, opd});
      in_valid = 1'b1; in_opcode = op; in_reg_sel = rs; in_operand = opd;
      @(posedge clock); #1;
      total++; if (level !== 3'd1) $display("FAIL b2b_level[%0d] got %0d want 1", i, level); else pass_cnt++;
    end
    in_valid = 1'b0;
    idle(3);
    total++; if (iss_q.size() !== n) $display("FAIL b2b_count got %0d want %0d", iss_q.size(), n); else pass_cnt++;
    for (int i = 0; i < n && i < iss_q.size(); i++) begin
      total++; if (iss_q[i] !== exp_q[i]) $display("FAIL b2b_byte[%0d] got %h want %h", i, iss_q[i], exp_q[i]); else pass_cnt++;
      if (i > 0) begin
        total++; if (iss_t[i] - iss_t[i-1] !== 1)
          $display("FAIL b2b_spacing[%0d] got %0d want 1", i, iss_t[i] - iss_t[i-1]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_back_to_back;
    stream(249, 0);
    total++; if (issued_count !== 8'd0) $display("FAIL b2b_wrap got %0d want 0", issued_count); else pass_cnt++;
    stream(11, 37);
    total++; if (issued_count !== 8'd11) $display("FAIL b2b_after_wrap got %0d want 11", issued_count); else pass_cnt++;
  endtask

  task automatic fill_gap5;
    gap = 4'd5; iss_q.delete(); iss_t.delete();
    in_valid = 1'b1; in_reg_sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_opcode = 3'b001; in_operand = 4'(i + 1);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush;
    fill_gap5;
    total++; if ({level, busy} !== 4'b011_1) $display("FAIL preflush got level=%0d busy=%b want 3/1", level, busy); else pass_cnt++;
    flush = 1'b1; in_valid = 1'b1; in_opcode = 3'b010; in_operand = 4'h9; #1;
    total++; if (in_ready !== 1'b0) $display("FAIL flush_ready got %b want 0", in_ready); else pass_cnt++;
    @(posedge clock); #1; flush = 1'b0; in_valid = 1'b0;
    total++; if ({level, busy} !== 4'd0) $display("FAIL flush_state got level=%0d busy=%b want 0/0", level, busy); else pass_cnt++;
    total++; if ({instr_out, instr_ena} !== 9'd0) $display("FAIL flush_out got out=%h ena=%b want 00/0", instr_out, instr_ena); else pass_cnt++;
    idle(10);
    total++; if (iss_q.size() !== 1) $display("FAIL flush_no_issue got %0d pulses want 1", iss_q.size()); else pass_cnt++;
    total++; if ({issued_count, reject_count} !== {8'd12, 4'd15})
      $display("FAIL flush_counters got issued=%0d reject=%0d want 12/15", issued_count, reject_count);
    else pass_cnt++;
    gap = 4'd0;
    send(3'b001, 1'b0, 4'h7);
    idle(1);
    total++; if ({instr_ena, instr_out} !== {1'b1, 8'h27})
      $display("FAIL postflush_issue got ena=%b out=%h want 1/27", instr_ena, instr_out);
    else pass_cnt++;
    idle(1);
    total++; if (instr_ena !== 1'b0) $display("FAIL postflush_pulse got ena=%b want 0", instr_ena); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    fill_gap5;
    total++; if ({level, busy} !== 4'b011_1) $display("FAIL premid got level=%0d busy=%b want 3/1", level, busy); else pass_cnt++;
    reset = 1'b1; #1;
    total++; if ({instr_out, instr_ena, level, busy} !== 13'd0)
      $display("FAIL midreset_outputs got out=%h ena=%b level=%0d busy=%b want all 0", instr_out, instr_ena, level, busy);
    else pass_cnt++;
    total++; if ({issued_count, reject_count} !== 12'd0)
      $display("FAIL midreset_counters got issued=%0d reject=%0d want 0/0", issued_count, reject_count);
    else pass_cnt++;
    iss_q.delete(); iss_t.delete();
    @(posedge clock); #1; reset = 1'b0;
    idle(10);
    total++; if (iss_q.size() !== 0) $display("FAIL midreset_no_issue got %0d pulses want 0", iss_q.size()); else pass_cnt++;
    gap = 4'd0;
    send(3'b011, 1'b1, 4'h2);
    idle(3);
    total++; if (iss_q.size() !== 1) $display("FAIL midreset_new got %0d pulses want 1", iss_q.size()); else pass_cnt++;
    if (iss_q.size() > 0) begin
      total++; if (iss_q[0] !== 8'h72) $display("FAIL midreset_byte got %h want 72", iss_q[0]); else pass_cnt++;
    end
    total++; if (issued_count !== 8'd1) $display("FAIL midreset_issued got %0d want 1", issued_count); else pass_cnt++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout after %0d cycles", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_basic;
    test_nop_undef;
    test_gap_full;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
`default_nettype wire
